// File: rtl/audio_record.sv
// Records DEPTH mono samples from the codec input FIFO into a single-port RAM.
// Optional clip detection is enabled with `define AUDIO_RECORD_CLIP_DETECT_EN.
module audio_record #(
  parameter int unsigned DEPTH  = 48000,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              read_ready,
  input  logic [23:0]       readdata_left,
  input  logic [23:0]       readdata_right,
  output logic              read,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_data,
  output logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              clip
);

  typedef enum logic [2:0] {StIdle, StWait, StCapture, StStore, StFinish} state_t;

  state_t      state, state_d;
  logic [23:0] left_q, right_q;
  logic signed [24:0] sum;
  logic        last;

  assign last     = (count == ADDR_W'(DEPTH - 1));
  assign mem_addr = count;

  always_comb begin
    state_d = state;
    unique case (state)
      StIdle:    if (start) state_d = StWait;
      StWait:    if (read_ready) state_d = StCapture;
      StCapture: state_d = StStore;
      StStore:   state_d = last ? StFinish : StWait;
      StFinish:  if (!start) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      read     <= 1'b0;
      mem_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      left_q   <= '0;
      right_q  <= '0;
    end else begin
      state    <= state_d;
      read     <= (state_d == StCapture);
      mem_wren <= (state_d == StStore);
      busy     <= (state_d == StWait) || (state_d == StCapture) || (state_d == StStore);
      done     <= (state_d == StFinish);
      if (state == StIdle && start) count <= '0;
      else if (state == StStore) count <= count + ADDR_W'(1);
      if (state == StCapture) begin
        left_q  <= readdata_left;
        right_q <= readdata_right;
      end
    end
  end

  // Mono mix: 25-bit sum of sign-extended channels, arithmetic shift right by one.
  assign sum = $signed({left_q[23], left_q}) + $signed({right_q[23], right_q});

  always_comb begin
    mem_data = 24'(sum >>> 1);
  end

`ifdef AUDIO_RECORD_CLIP_DETECT_EN
  logic clip_hit;

  assign clip_hit = (readdata_left == 24'h7FFFFF) || (readdata_left == 24'h800000) ||
                    (readdata_right == 24'h7FFFFF) || (readdata_right == 24'h800000);

  always_ff @(posedge clk) begin
    if (reset) begin
      clip <= 1'b0;
    end else if (state == StIdle && start) begin
      clip <= 1'b0;
    end else if (state == StCapture && clip_hit) begin
      clip <= 1'b1;
    end
  end
`else
  assign clip = 1'b0;
`endif

endmodule
